bcd_result_converter: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the signed sequential multiplier. It captures the 15-bit product magnitude and sign when the multiplier signals completion. It converts the magnitude to five packed BCD digits with a shift-and-add-3 (double-dabble) engine, one bit per clock. It then presents a registered decimal result, with sign, to the seven-segment display driver.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_adjust.sv | 18 +
 rtl/bcd_result_converter.sv | 145 ++++++++++++++
 tb/tb_bcd_result_converter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD result converter.
//   PRODUCT_W   : multiplier product magnitude width
//   BCD_DIGITS  : number of decimal digits presented to the display
//   BLANK_DIGIT : display driver code for a dark digit
//   state_e     : converter FSM states
package bcd_pkg;

  localparam int unsigned PRODUCT_W  = 15;
  localparam int unsigned BCD_DIGITS = 5;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   digit    : current working BCD digit
//   adjusted : corrected digit, ready to be shifted
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_result_converter.sv
// Sequential binary-to-BCD converter for the signed multiplier result.
// Captures magnitude/sign on start (in IDLE), runs one double-dabble step per
// clock for IN_W cycles, then registers the packed BCD value and sign and
// pulses done for one cycle.
// Ports:
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   start     : conversion request, only honoured in IDLE
//   sign      : 1 = product negative
//   magnitude : unsigned product magnitude
//   busy      : state is not IDLE
//   done      : one-cycle pulse, new result on bcd/neg
//   neg       : registered result sign (never set for zero)
//   bcd       : registered packed BCD, digit 0 in bcd[3:0]
// Build option: LEADING_ZERO_BLANK_EN replaces leading zero digits (except
// digit 0) with BLANK_DIGIT and makes the reset value display a lone "0".
module bcd_result_converter
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W   = PRODUCT_W,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  sign,
  input  logic [IN_W-1:0]       magnitude,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [BCD_W-1:0] BCD_RST = {{(DIGITS - 1){BLANK_DIGIT}}, 4'h0};
`else
  localparam logic [BCD_W-1:0] BCD_RST = '0;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]  work_q, work_d;
  logic              sign_q, sign_d;
  logic              neg_q, neg_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (work_q[4*g +: 4]),
      .adjusted (adj[4*g +: 4])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank every zero digit above the most significant nonzero one.
  function automatic logic [BCD_W-1:0] format_result(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             leading;
    r       = v;
    leading = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = BLANK_DIGIT;
      end else begin
        leading = 1'b0;
      end
    end
    return r;
  endfunction
`else
  function automatic logic [BCD_W-1:0] format_result(input logic [BCD_W-1:0] v);
    return v;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    work_d  = work_q;
    sign_d  = sign_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = magnitude;
          work_d  = '0;
          cnt_d   = '0;
          sign_d  = sign & (magnitude != '0);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Add-3 never overflows the top digit given 10^DIGITS > 2^IN_W - 1.
        {work_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d           = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_d   = format_result(work_d);
          neg_d   = sign_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      work_q  <= '0;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= BCD_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign neg  = neg_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_result_converter.sv
// Self-checking bench for bcd_result_converter: expected results are pushed
// into a scoreboard queue at stimulus time and popped by a monitor on done.
module tb_bcd_result_converter;

  localparam int IN_W   = 15;
  localparam int DIGITS = 5;
  localparam int BCD_W  = 4 * DIGITS;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              sign;
  logic [IN_W-1:0]   magnitude;
  logic              busy;
  logic              done;
  logic              neg;
  logic [BCD_W-1:0]  bcd;

  int vectors;
  int miscompares;
  int done_cnt;

  logic [BCD_W:0] exp_q[$];

  bcd_result_converter #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .sign      (sign),
    .magnitude (magnitude),
    .busy      (busy),
    .done      (done),
    .neg       (neg),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits by plain division, then optional leading-zero blanking.
  function automatic logic [BCD_W-1:0] ref_bcd(input int m);
    logic [BCD_W-1:0] r;
    int v;
    int top;
    v   = m;
    r   = '0;
    top = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      if ((v % 10) != 0) top = i;
      v = v / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = top + 1; i < DIGITS; i++) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] rst_bcd();
`ifdef LEADING_ZERO_BLANK_EN
    return {{(DIGITS - 1){4'hF}}, 4'h0};
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bcd), 32'hDEAD_BEEF);
      end else begin
        logic [BCD_W:0] e;
        e = exp_q.pop_front();
        chk("result_bcd", 32'(bcd), 32'(e[BCD_W-1:0]));
        chk("result_neg", 32'(neg), 32'(e[BCD_W]));
      end
    end
  end

  task automatic push_exp(input int m, input logic s);
    exp_q.push_back({s & (m != 0), ref_bcd(m)});
  endtask

  // Wait (bounded) for done; returns edges elapsed, -1 on timeout.
  task automatic wait_done(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        k = i;
        break;
      end
    end
    if (k < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // One conversion; start is sampled on the next edge (E0).
  task automatic convert(input int m, input logic s, input bit check_timing);
    int k;
    push_exp(m, s);
    magnitude = IN_W'(m);
    sign      = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (check_timing) chk("busy_rise", 32'(busy), 32'd1);
    wait_done(40, k);
    if (check_timing) begin
      chk("done_latency", 32'(k), 32'd15);
      @(posedge clk); #1;
      chk("done_width", 32'(done), 32'd0);
      chk("busy_fall", 32'(busy), 32'd0);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int k;
    int d0;
    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    start       = 1'b0;
    sign        = 1'b0;
    magnitude   = '0;
    reset_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_neg", 32'(neg), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'(rst_bcd()));

    convert(16256, 1'b0, 1'b1);
    convert(32767, 1'b1, 1'b1);
    convert(0, 1'b1, 1'b1);
    convert(45, 1'b0, 1'b0);
    chk("hold_bcd", 32'(bcd), 32'(ref_bcd(45)));

    // Request raised while busy is lost.
    d0 = done_cnt;
    push_exp(100, 1'b0);
    magnitude = IN_W'(100);
    sign      = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    magnitude = IN_W'(999);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("lost_req_dones", 32'(done_cnt - d0), 32'd1);
    chk("lost_req_bcd", 32'(bcd), 32'(ref_bcd(100)));

    // Reset mid-conversion aborts with no done.
    d0 = done_cnt;
    magnitude = IN_W'(12345);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_neg", 32'(neg), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'(rst_bcd()));
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    convert(7, 1'b0, 1'b1);

    // start held high: a second conversion starts on return to IDLE.
    push_exp(9876, 1'b1);
    push_exp(9876, 1'b1);
    magnitude = IN_W'(9876);
    sign      = 1'b1;
    start     = 1'b1;
    wait_done(40, k);
    @(posedge clk); #1;
    chk("held_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("held_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(40, k);
    @(posedge clk); #1;

    // Randomized conversions, edge magnitudes mixed in.
    for (int i = 0; i < 40; i++) begin
      int m;
      case (i % 10)
        0:       m = 0;
        1:       m = 32767;
        2:       m = 10000;
        default: m = int'($urandom_range(0, 32767));
      endcase
      convert(m, 1'($urandom), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
